serial_xfer_ctrl: RTL and testbench

Sequencer that drives the DMG serial port (SB at FF01, SC at FF02) over the CPU bus on behalf of a byte-stream client. It queues outgoing bytes in a small FIFO, loads SB, starts the transfer through SC, and waits for the serial interrupt. It then reads the received byte back from SB and hands it out on a valid/ready port. It sits beside the CPU bus model in the simulation top and replaces hand-written bus sequences for link-cable traffic.

---
 rtl/serial_pkg.sv | 28 ++
 rtl/serial_tx_fifo.sv | 67 ++++++
 rtl/serial_xfer_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_serial_xfer_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: shared definitions for the link-cable serial sequencer.
// Holds the sequencer state encoding, the DMG serial register addresses
// and the SC control values written to start or stop a transfer.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR_SB = 3'd1,
    WR_SC = 3'd2,
    WAIT  = 3'd3,
    RD_SB = 3'd4,
    PUSH  = 3'd5,
    ABORT = 3'd6
  } state_e;

  localparam logic [15:0] ADDR_SB = 16'hFF01;
  localparam logic [15:0] ADDR_SC = 16'hFF02;

  localparam logic [7:0] SC_START_INT = 8'h81;
  localparam logic [7:0] SC_START_EXT = 8'h80;
  localparam logic [7:0] SC_STOP      = 8'h00;

  // SC value that starts a transfer; bit 0 selects the internal shift clock.
  function automatic logic [7:0] sc_start(input logic ext_clk);
    return ext_clk ? SC_START_EXT : SC_START_INT;
  endfunction

endpackage

// File: rtl/serial_tx_fifo.sv
// serial_tx_fifo: small synchronous byte FIFO holding bytes waiting to be
// shifted out.
// Ports:
//   clk, reset   clock and synchronous active-high reset (empties the queue)
//   push, din    write request and byte; ignored while full
//   pop, dout    read request and head byte (dout shows the head while !empty)
//   full, empty  occupancy flags derived from the registered count
module serial_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W + 1)'(DEPTH);

  logic [7:0]       mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CNT_FULL);
  assign empty     = (count_r == {(PTR_W + 1){1'b0}});
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign dout      = mem_r[rd_ptr_r];

  // Storage array; only written on an accepted push, so it needs no reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W + 1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/serial_xfer_ctrl.sv
// serial_xfer_ctrl: drives the DMG serial port over the CPU bus for a
// byte-stream client. Queued bytes are written to SB, started through SC,
// and the received byte is read back from SB after the serial interrupt.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   tx_data/valid/ready    client byte input (accepted when valid & ready)
//   ext_clk                shift-clock select latched when a byte is popped
//   rx_data/valid/ready    received byte output, held until rx_ready
//   a, d_out, d_in         CPU bus address, write data, read data
//   cpu_wr, cpu_rd         one-cycle bus strobes
//   int_serial             serial interrupt level
//   busy, timeout          not-idle status, one-cycle abort pulse
// All bus and status outputs are registered from the next state, so they
// line up exactly with the state that owns them.
module serial_xfer_ctrl
  import serial_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic        ext_clk,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [15:0] a,
  output logic [7:0]  d_out,
  input  logic [7:0]  d_in,
  output logic        cpu_wr,
  output logic        cpu_rd,
  input  logic        int_serial,
  output logic        busy,
  output logic        timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_r;
  state_e           next_state_s;
  logic             ext_clk_r;
  logic [CNT_W-1:0] cnt_r;
  logic             int_prev_r;
  logic             edge_r;

  logic             fifo_push_s;
  logic             fifo_pop_s;
  logic [7:0]       fifo_dout_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;

  logic [15:0]      a_nxt_s;
  logic [7:0]       d_out_nxt_s;
  logic             wr_nxt_s;
  logic             rd_nxt_s;

  logic [15:0]      a_r;
  logic [7:0]       d_out_r;
  logic             cpu_wr_r;
  logic             cpu_rd_r;
  logic [7:0]       rx_data_r;
  logic             rx_valid_r;
  logic             busy_r;
  logic             timeout_r;

  assign fifo_push_s = tx_valid & ~fifo_full_s;
  assign tx_ready    = ~fifo_full_s;

  serial_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push_s),
    .pop   (fifo_pop_s),
    .din   (tx_data),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Next-state decode; the FIFO pop happens in the IDLE cycle that starts a transfer.
  always_comb begin
    next_state_s = state_r;
    fifo_pop_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) begin
          fifo_pop_s   = 1'b1;
          next_state_s = WR_SB;
        end else begin
          next_state_s = IDLE;
        end
      end
      WR_SB: next_state_s = WR_SC;
      WR_SC: next_state_s = WAIT;
      WAIT: begin
        // A completed shift wins over a timeout landing in the same cycle.
        if (edge_r) begin
          next_state_s = RD_SB;
        end else if (cnt_r == CNT_LAST) begin
          next_state_s = ABORT;
        end else begin
          next_state_s = WAIT;
        end
      end
      RD_SB: next_state_s = PUSH;
      PUSH: begin
        if (rx_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = PUSH;
        end
      end
      ABORT:   next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Bus values for the state about to be entered, registered below.
  always_comb begin
    a_nxt_s     = 16'h0000;
    d_out_nxt_s = 8'h00;
    wr_nxt_s    = 1'b0;
    rd_nxt_s    = 1'b0;
    case (next_state_s)
      WR_SB: begin
        a_nxt_s     = ADDR_SB;
        d_out_nxt_s = fifo_dout_s;
        wr_nxt_s    = 1'b1;
      end
      WR_SC: begin
        a_nxt_s     = ADDR_SC;
        d_out_nxt_s = sc_start(ext_clk_r);
        wr_nxt_s    = 1'b1;
      end
      RD_SB: begin
        a_nxt_s  = ADDR_SB;
        rd_nxt_s = 1'b1;
      end
      ABORT: begin
        a_nxt_s     = ADDR_SC;
        d_out_nxt_s = SC_STOP;
        wr_nxt_s    = 1'b1;
      end
      default: begin
        a_nxt_s     = 16'h0000;
        d_out_nxt_s = 8'h00;
      end
    endcase
  end

  // State register, transfer context and wait-cycle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      ext_clk_r <= 1'b0;
      cnt_r     <= {CNT_W{1'b0}};
    end else begin
      state_r <= next_state_s;
      if (fifo_pop_s) begin
        ext_clk_r <= ext_clk;
      end
      if (state_r == WR_SC) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (state_r == WAIT) begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  // Interrupt edge detect runs in every state so an edge during WR_SC reaches WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      int_prev_r <= 1'b0;
      edge_r     <= 1'b0;
    end else begin
      int_prev_r <= int_serial;
      edge_r     <= int_serial & ~int_prev_r;
    end
  end

  // Registered bus strobes, receive holding register and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r        <= 16'h0000;
      d_out_r    <= 8'h00;
      cpu_wr_r   <= 1'b0;
      cpu_rd_r   <= 1'b0;
      rx_data_r  <= 8'h00;
      rx_valid_r <= 1'b0;
      busy_r     <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      a_r        <= a_nxt_s;
      d_out_r    <= d_out_nxt_s;
      cpu_wr_r   <= wr_nxt_s;
      cpu_rd_r   <= rd_nxt_s;
      if (state_r == RD_SB) begin
        rx_data_r <= d_in;
      end
      rx_valid_r <= (next_state_s == PUSH);
      busy_r     <= (next_state_s != IDLE);
      timeout_r  <= (next_state_s == ABORT);
    end
  end

  assign a        = a_r;
  assign d_out    = d_out_r;
  assign cpu_wr   = cpu_wr_r;
  assign cpu_rd   = cpu_rd_r;
  assign rx_data  = rx_data_r;
  assign rx_valid = rx_valid_r;
  assign busy     = busy_r;
  assign timeout  = timeout_r;

endmodule

// File: tb/tb_serial_xfer_ctrl.sv
// Scoreboard bench for serial_xfer_ctrl. The main process offers bytes and
// records each accepted byte; a serial-port model answers SC start writes
// by scheduling the interrupt and the byte read back from SB; a monitor
// checks every bus strobe, abort and rx handshake against those records.
module tb_serial_xfer_ctrl;

  localparam int TO    = 200;
  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        ext_clk;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [15:0] a;
  logic [7:0]  d_out;
  logic [7:0]  sb_reg;
  logic        cpu_wr;
  logic        cpu_rd;
  logic        int_serial;
  logic        busy;
  logic        timeout;

  serial_xfer_ctrl #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ext_clk    (ext_clk),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .a          (a),
    .d_out      (d_out),
    .d_in       (sb_reg),
    .cpu_wr     (cpu_wr),
    .cpu_rd     (cpu_rd),
    .int_serial (int_serial),
    .busy       (busy),
    .timeout    (timeout)
  );

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int strobe_cnt = 0;
  int xfer_cnt = 0;

  // main-process controls read by the serial-port model
  int periph_mode;   // 0 answer after a delay, 1 never answer, 2 level already high
  int rdy_mode;      // 0 random rx_ready, 1 always ready, 2 never ready
  int fix_idx;
  int fix_delay;
  bit fix_rx_en;
  logic [7:0] fix_rx;
  int cancel_gen;

  logic [7:0] tx_model_q[$];
  logic [7:0] exp_rx_q[$];
  int         exp_rd_q[$];
  int         exp_to_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %0h, expected no such event (cycle %0d)", name, act, cyc);
  endtask

  // Serial-port model: owns int_serial, SB contents and rx_ready.
  initial begin : periph
    int raise_at;
    int drop_at;
    int cancel_seen;
    int d;
    raise_at = -1; drop_at = -1; cancel_seen = 0;
    int_serial = 1'b0; sb_reg = 8'h00; rx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (cancel_gen != cancel_seen) begin
        cancel_seen = cancel_gen;
        raise_at = -1; drop_at = -1; int_serial = 1'b0;
      end else if (!reset) begin
        if (periph_mode == 2 && raise_at < 0 && drop_at < 0) int_serial = 1'b1;
        if (cpu_wr && a == 16'hFF02 && d_out[7]) begin
          if (periph_mode == 1) begin
            int_serial = 1'b0;
            exp_to_q.push_back(cyc + 1 + TO);
          end else begin
            if (periph_mode == 2) begin
              drop_at = cyc + 30; raise_at = cyc + 33;
            end else begin
              d = (xfer_cnt == fix_idx) ? fix_delay : $urandom_range(2, 40);
              int_serial = 1'b0; raise_at = cyc + d;
            end
            sb_reg = (xfer_cnt == fix_idx && fix_rx_en) ? fix_rx : 8'($urandom_range(0, 255));
            exp_rx_q.push_back(sb_reg);
            exp_rd_q.push_back(raise_at + 2);
          end
          xfer_cnt++;
        end
        if (cyc == drop_at) begin int_serial = 1'b0; drop_at = -1; end
        if (cyc == raise_at) begin int_serial = 1'b1; raise_at = -1; end
        if (cpu_rd) int_serial = 1'b0;
      end
      rx_ready = (rdy_mode == 0) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
    end
  end

  // Monitor: compares every observed DUT action with the scoreboard queues.
  initial begin : monitor
    logic pv, pr, hs_prev, rd_prev, hs;
    logic [7:0] pd;
    int sb_cyc;
    pv = 0; pr = 0; pd = 8'h00; hs_prev = 0; rd_prev = 0; sb_cyc = -10;
    forever begin
      @(negedge clk);
      if (reset) begin
        pv = 0; pr = 0; hs_prev = 0; rd_prev = 0;
      end else begin
        if (cpu_wr || cpu_rd) strobe_cnt++;
        if (cpu_wr && cpu_rd) fail_now("wr_rd_overlap", {a, d_out});
        if (cpu_wr) begin
          if (a == 16'hFF01) begin
            if (tx_model_q.size() == 0) fail_now("sb_wr_unexpected", d_out);
            else chk("sb_wr_data", d_out, tx_model_q.pop_front());
            sb_cyc = cyc;
          end else if (a == 16'hFF02 && d_out != 8'h00) begin
            chk("sc_start_data", d_out, ext_clk ? 8'h80 : 8'h81);
            chk("sc_after_sb", cyc, sb_cyc + 1);
          end else if (a == 16'hFF02) begin
            if (exp_to_q.size() == 0) fail_now("abort_unexpected", cyc);
            else chk("abort_cycle", cyc, exp_to_q.pop_front());
            chk("abort_timeout_pulse", timeout, 1);
          end else begin
            fail_now("wr_bad_addr", a);
          end
        end else if (!cpu_rd) begin
          chk("bus_idle", {a, d_out, timeout}, 0);
        end
        if (cpu_rd) begin
          chk("rd_addr", a, 16'hFF01);
          if (exp_rd_q.size() == 0) fail_now("rd_unexpected", cyc);
          else chk("rd_cycle", cyc, exp_rd_q.pop_front());
        end
        if (rd_prev) chk("rx_after_rd", {rx_valid, rx_data}, {1'b1, sb_reg});
        if (pv && !pr) chk("rx_hold", {rx_valid, rx_data}, {1'b1, pd});
        if (hs_prev) chk("busy_after_rx", busy, 0);
        hs = rx_valid && rx_ready;
        if (hs) begin
          if (exp_rx_q.size() == 0) fail_now("rx_unexpected", rx_data);
          else chk("rx_data", rx_data, exp_rx_q.pop_front());
        end
        hs_prev = hs; pv = rx_valid; pr = rx_ready; pd = rx_data; rd_prev = cpu_rd;
      end
    end
  end

  // Offer one byte; called and returning just after a rising edge.
  task automatic push_byte(input logic [7:0] b, input int bound, output int waited);
    bit ok;
    ok = 0; waited = 0;
    tx_data = b; tx_valid = 1'b1;
    while (!ok && waited < bound) begin
      @(negedge clk);
      if (tx_ready) begin
        ok = 1;
        tx_model_q.push_back(b);
      end else begin
        waited++;
      end
      @(posedge clk);
      #1;
    end
    tx_valid = 1'b0;
    if (!ok) fail_now("push_timeout", b);
  endtask

  task automatic wait_idle(input int bound);
    int k;
    bit idle;
    k = 0; idle = 0;
    while (!idle && k < bound) begin
      @(negedge clk);
      k++;
      idle = !busy && tx_model_q.size() == 0 && exp_rx_q.size() == 0 &&
             exp_rd_q.size() == 0 && exp_to_q.size() == 0;
    end
    if (!idle) fail_now("idle_timeout", k);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sc(input int target, input int bound);
    int k;
    k = 0;
    while (xfer_cnt < target && k < bound) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (xfer_cnt < target) fail_now("sc_wait_timeout", k);
  endtask

  task automatic check_reset_vals();
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx", {rx_valid, rx_data}, 0);
    chk("rst_bus", {a, d_out, cpu_wr, cpu_rd}, 0);
    chk("rst_status", {busy, timeout}, 0);
  endtask

  initial begin : main
    int w;
    int s0;
    int k;
    reset = 1'b1; tx_data = 8'h00; tx_valid = 1'b0; ext_clk = 1'b0;
    periph_mode = 0; rdy_mode = 1; fix_idx = -1; fix_delay = 2;
    fix_rx_en = 0; fix_rx = 8'h00; cancel_gen = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_vals();
    @(posedge clk);
    #1;

    // first transfer: 0xA5, internal clock, interrupt 100 cycles after start
    fix_idx = xfer_cnt; fix_delay = 100; fix_rx_en = 1; fix_rx = 8'h3C;
    push_byte(8'hA5, 10, w);
    wait_idle(400);
    fix_rx_en = 0;

    // queue fills while the first byte is stalled in WAIT
    fix_idx = xfer_cnt; fix_delay = 150; rdy_mode = 0;
    push_byte(8'($urandom_range(0, 255)), 10, w);
    wait_sc(fix_idx + 1, 50);
    for (int i = 0; i < DEPTH; i++) push_byte(8'($urandom_range(0, 255)), 10, w);
    chk("fifo_full_tx_ready", tx_ready, 0);
    push_byte(8'($urandom_range(0, 255)), 400, w);
    chk("fifo_fifth_stalled", (w > 50), 1);
    wait_idle(3000);

    // rx client holds off: output stays put and the next byte waits
    rdy_mode = 2;
    push_byte(8'($urandom_range(0, 255)), 10, w);
    push_byte(8'($urandom_range(0, 255)), 10, w);
    k = 0;
    while (!rx_valid && k < 200) begin @(negedge clk); k++; end
    if (!rx_valid) fail_now("hold_rx_never_valid", k);
    s0 = strobe_cnt;
    repeat (50) @(negedge clk);
    chk("hold_no_start", strobe_cnt - s0, 0);
    chk("hold_rx_valid", rx_valid, 1);
    @(posedge clk);
    #1 rdy_mode = 1;
    wait_idle(400);

    // no interrupt at all: abort with SC stop write and timeout pulse
    periph_mode = 1; ext_clk = 1'b1;
    push_byte(8'($urandom_range(0, 255)), 10, w);
    wait_idle(600);

    // interrupt level already high on entry: only a fresh edge completes
    periph_mode = 2; ext_clk = 1'($urandom_range(0, 1));
    repeat (3) begin @(posedge clk); #1; end
    push_byte(8'($urandom_range(0, 255)), 10, w);
    wait_idle(400);

    // random traffic in batches
    periph_mode = 0; rdy_mode = 0;
    for (int b = 0; b < 5; b++) begin
      ext_clk = 1'($urandom_range(0, 1));
      for (int i = 0; i < int'($urandom_range(2, 6)); i++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        push_byte(8'($urandom_range(0, 255)), 400, w);
      end
      wait_idle(3000);
    end

    // reset in WAIT with two bytes still queued
    rdy_mode = 1; fix_idx = xfer_cnt; fix_delay = 150;
    for (int i = 0; i < 3; i++) push_byte(8'($urandom_range(0, 255)), 10, w);
    wait_sc(fix_idx + 1, 50);
    repeat (5) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_vals();
    tx_model_q.delete(); exp_rx_q.delete(); exp_rd_q.delete(); exp_to_q.delete();
    cancel_gen = cancel_gen + 1;
    s0 = strobe_cnt;
    repeat (100) @(negedge clk);
    chk("post_reset_no_strobe", strobe_cnt - s0, 0);
    chk("post_reset_empty", {tx_ready, busy}, 2'b10);
    @(posedge clk);
    #1;

    // recovery transfer after the reset
    push_byte(8'($urandom_range(0, 255)), 10, w);
    wait_idle(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
